// File: rtl/stack_pkg.sv
// Shared definitions for the call/return stack sequencer.
package stack_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PUSH_WR   = 3'd1,
    PULL_RD   = 3'd2,
    PULL_WAIT = 3'd3,
    DONE      = 3'd4,
    ERR       = 3'd5
  } state_t;

  localparam int unsigned SP_INIT_DEF    = 32'h0000_0058;
  localparam int unsigned SP_LIMIT_DEF   = 32'h0000_0018;
  localparam int unsigned WORD_BYTES_DEF = 4;

endpackage

// File: rtl/stack_sp_reg.sv
// Architectural stack pointer: resets to the empty-stack address, steps by one
// word on inc/dec, and decodes full/empty from the registered value.
module stack_sp_reg
  import stack_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int unsigned SP_INIT    = SP_INIT_DEF,
  parameter int unsigned SP_LIMIT   = SP_LIMIT_DEF,
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              inc,
  input  logic              dec,
  output logic [DATA_W-1:0] sp,
  output logic              full,
  output logic              empty
);

  localparam logic [DATA_W-1:0] INIT_V  = DATA_W'(SP_INIT);
  localparam logic [DATA_W-1:0] LIMIT_V = DATA_W'(SP_LIMIT);
  localparam logic [DATA_W-1:0] STEP_V  = DATA_W'(WORD_BYTES);

  // SP update on the register-file edge; reset overrides any pending step.
  always_ff @(negedge Clock) begin
    if (!Resetn) begin
      sp <= INIT_V;
    end else if (dec) begin
      sp <= sp - STEP_V;
    end else if (inc) begin
      sp <= sp + STEP_V;
    end
  end

  assign full  = (sp == LIMIT_V);
  assign empty = (sp == INIT_V);

endmodule

// File: rtl/stack_ctrl.sv
// Call/return stack sequencer: accepts one push or pull from IDLE, drives a
// word-addressed RAM with 1-cycle read latency, and hands the new SP back for
// write-back into r29. Outputs are registered from the current state, so each
// state's action appears one negedge after the state is entered.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int unsigned SP_INIT    = SP_INIT_DEF,
  parameter int unsigned SP_LIMIT   = SP_LIMIT_DEF,
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              push_req,
  input  logic              pull_req,
  input  logic [DATA_W-1:0] push_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] pull_data,
  output logic [DATA_W-1:0] sp_out,
  output logic              sp_we,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(WORD_BYTES);

  // Misaligned stack bounds would put non-zero bits in mem_addr[1:0].
  if ((SP_INIT % 4) != 0 || (SP_LIMIT % 4) != 0 || (WORD_BYTES % 4) != 0 ||
      SP_LIMIT > SP_INIT) begin : g_bad_cfg
    $error("stack_ctrl: SP_INIT/SP_LIMIT/WORD_BYTES must be word-aligned with SP_LIMIT <= SP_INIT");
  end

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] data_lat;
  logic              rd_wait;
  logic              sp_inc, sp_dec;

  assign sp_dec = (state == PUSH_WR);
  assign sp_inc = (state == PULL_WAIT);

  stack_sp_reg #(
    .DATA_W     (DATA_W),
    .SP_INIT    (SP_INIT),
    .SP_LIMIT   (SP_LIMIT),
    .WORD_BYTES (WORD_BYTES)
  ) u_sp (
    .Clock  (Clock),
    .Resetn (Resetn),
    .inc    (sp_inc),
    .dec    (sp_dec),
    .sp     (sp),
    .full   (full),
    .empty  (empty)
  );

  assign sp_out = sp;

  // State register.
  always_ff @(negedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; requests are only looked at in IDLE, never queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (push_req && pull_req) begin
          state_nxt = ERR;
        end else if (push_req) begin
          state_nxt = full ? ERR : PUSH_WR;
        end else if (pull_req) begin
          state_nxt = empty ? ERR : PULL_RD;
        end
      end
      PUSH_WR:   state_nxt = DONE;
      PULL_RD:   state_nxt = PULL_WAIT;
      PULL_WAIT: state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      ERR:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Capture the return address at acceptance so the requester may change it.
  always_ff @(negedge Clock) begin
    if (state == IDLE && push_req && !pull_req && !full) begin
      data_lat <= push_data;
    end
  end

  // Registered outputs: strobes, address/data and the popped word.
  always_ff @(negedge Clock) begin
    if (!Resetn) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      sp_we     <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pull_data <= '0;
      rd_wait   <= 1'b0;
    end else begin
      busy      <= (state != IDLE);
      done      <= (state == DONE);
      sp_we     <= (state == DONE);
      err       <= (state == ERR);
      mem_we    <= (state == PUSH_WR);
      mem_re    <= (state == PULL_RD);
      rd_wait   <= (state == PULL_WAIT);
      mem_addr  <= '0;
      mem_wdata <= '0;
      if (state == PUSH_WR) begin
        mem_addr  <= sp - STEP_V;
        mem_wdata <= data_lat;
      end
      if (state == PULL_RD) begin
        mem_addr <= sp;
      end
      // RAM data arrives one cycle after the read strobe, alongside done.
      if (rd_wait) begin
        pull_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural 1-cycle-latency RAM.
module tb_stack_ctrl;

  logic        Clock = 1'b1;
  logic        Resetn = 1'b0;
  logic        push_req = 1'b0;
  logic        pull_req = 1'b0;
  logic [31:0] push_data = '0;
  logic        busy, done, err, sp_we, full, empty, mem_we, mem_re;
  logic [31:0] pull_data, sp_out, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:31] = '{default: 32'h0};

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  stack_ctrl dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .push_req  (push_req),
    .pull_req  (pull_req),
    .push_data (push_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pull_data (pull_data),
    .sp_out    (sp_out),
    .sp_we     (sp_we),
    .full      (full),
    .empty     (empty),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  // Word-addressed RAM, same edge as the DUT, read data one cycle after mem_re.
  always @(negedge Clock) begin
    if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[6:2]];
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic reset_dut();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
  endtask

  // Plain push used only to build up stack contents.
  task automatic do_push(input logic [31:0] d);
    push_req = 1'b1; push_data = d;
    tick();
    push_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    tick(); tick();
    checks++; if (sp_out !== 32'h58) begin errors++; $display("FAIL reset_sp: got %h expected %h", sp_out, 32'h58); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", empty, full); end
    checks++; if ({busy, done, err, sp_we, mem_we, mem_re} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 000000", {busy, done, err, sp_we, mem_we, mem_re}); end
    checks++; if (pull_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_data: got pd=%h addr=%h wd=%h expected 0", pull_data, mem_addr, mem_wdata); end
    Resetn = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || sp_out !== 32'h58) begin errors++; $display("FAIL idle_after_reset: got busy=%b sp=%h expected 0 58", busy, sp_out); end
  endtask

  task automatic test_push();
    push_req = 1'b1; push_data = 32'h0040_0010;
    tick();
    push_req = 1'b0; push_data = 32'hFFFF_FFFF;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("FAIL push_we: got we=%b re=%b expected 1 0", mem_we, mem_re); end
    checks++; if (mem_addr !== 32'h54) begin errors++; $display("FAIL push_addr: got %h expected %h", mem_addr, 32'h54); end
    checks++; if (mem_wdata !== 32'h0040_0010) begin errors++; $display("FAIL push_wdata: got %h expected %h", mem_wdata, 32'h0040_0010); end
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL push_p1_ctl: got done=%b busy=%b expected 0 1", done, busy); end
    tick();
    checks++; if (done !== 1'b1 || sp_we !== 1'b1) begin errors++; $display("FAIL push_done: got done=%b sp_we=%b expected 1 1", done, sp_we); end
    checks++; if (sp_out !== 32'h54 || mem_we !== 1'b0) begin errors++; $display("FAIL push_sp: got sp=%h we=%b expected 54 0", sp_out, mem_we); end
    checks++; if (mem[21] !== 32'h0040_0010) begin errors++; $display("FAIL push_ram: got %h expected %h", mem[21], 32'h0040_0010); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL push_idle: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  // Pull with full timing checks, used by the LIFO scenario.
  task automatic pull_op(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] sp_exp);
    pull_req = 1'b1;
    tick();
    pull_req = 1'b0;
    tick();
    checks++; if (mem_re !== 1'b1 || mem_addr !== addr) begin errors++; $display("FAIL pull_rd: got re=%b addr=%h expected 1 %h", mem_re, mem_addr, addr); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL pull_early_done: got %b expected 0", done); end
    tick();
    checks++; if (done !== 1'b1 || sp_we !== 1'b1) begin errors++; $display("FAIL pull_done: got done=%b sp_we=%b expected 1 1", done, sp_we); end
    checks++; if (pull_data !== data) begin errors++; $display("FAIL pull_data: got %h expected %h", pull_data, data); end
    checks++; if (sp_out !== sp_exp) begin errors++; $display("FAIL pull_sp: got %h expected %h", sp_out, sp_exp); end
  endtask

  task automatic test_lifo();
    reset_dut();
    push_req = 1'b1; push_data = 32'hA;
    tick(); push_req = 1'b0; tick();
    checks++; if (mem_addr !== 32'h54 || mem_we !== 1'b1) begin errors++; $display("FAIL lifo_push_a: got addr=%h we=%b expected 54 1", mem_addr, mem_we); end
    tick(); tick();
    push_req = 1'b1; push_data = 32'hB;
    tick(); push_req = 1'b0; tick();
    checks++; if (mem_addr !== 32'h50 || mem_wdata !== 32'hB) begin errors++; $display("FAIL lifo_push_b: got addr=%h wd=%h expected 50 b", mem_addr, mem_wdata); end
    tick(); tick();
    pull_op(32'h50, 32'hB, 32'h54);
    pull_op(32'h54, 32'hA, 32'h58);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lifo_empty: got %b expected 1", empty); end
  endtask

  task automatic test_errors();
    logic strobe_seen;
    pull_req = 1'b1;
    tick(); pull_req = 1'b0;
    strobe_seen = mem_we | mem_re;
    tick();
    strobe_seen = strobe_seen | mem_we | mem_re;
    checks++; if (err !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL empty_err: got err=%b done=%b expected 1 0", err, done); end
    checks++; if (sp_out !== 32'h58 || pull_data !== 32'hA) begin errors++; $display("FAIL empty_state: got sp=%h pd=%h expected 58 a", sp_out, pull_data); end
    tick();
    checks++; if (err !== 1'b0 || strobe_seen !== 1'b0) begin errors++; $display("FAIL empty_after: got err=%b strobes=%b expected 0 0", err, strobe_seen); end
    for (int i = 0; i < 16; i++) do_push(32'h100 + i);
    checks++; if (full !== 1'b1 || sp_out !== 32'h18) begin errors++; $display("FAIL fill: got full=%b sp=%h expected 1 18", full, sp_out); end
    push_req = 1'b1; push_data = 32'hBAD0_0000;
    tick(); push_req = 1'b0;
    strobe_seen = mem_we | mem_re;
    tick();
    strobe_seen = strobe_seen | mem_we | mem_re;
    checks++; if (err !== 1'b1 || sp_out !== 32'h18) begin errors++; $display("FAIL full_err: got err=%b sp=%h expected 1 18", err, sp_out); end
    tick();
    strobe_seen = strobe_seen | mem_we | mem_re;
    checks++; if (done !== 1'b0 || strobe_seen !== 1'b0) begin errors++; $display("FAIL full_quiet: got done=%b strobes=%b expected 0 0", done, strobe_seen); end
    checks++; if (mem[5] !== 32'h0 || mem[6] !== 32'h10F) begin errors++; $display("FAIL full_ram: got m5=%h m6=%h expected 0 10f", mem[5], mem[6]); end
    checks++; if (pull_data !== 32'hA) begin errors++; $display("FAIL full_pd: got %h expected a", pull_data); end
    pull_req = 1'b1;
    tick(); pull_req = 1'b0;
    tick(); tick(); tick();
    checks++; if (pull_data !== 32'h10F || sp_out !== 32'h1C || full !== 1'b0) begin errors++; $display("FAIL pull_at_full: got pd=%h sp=%h full=%b expected 10f 1c 0", pull_data, sp_out, full); end
  endtask

  task automatic test_both_and_busy();
    int n_done;
    logic we_seen;
    push_req = 1'b1; pull_req = 1'b1; push_data = 32'h77;
    tick(); push_req = 1'b0; pull_req = 1'b0;
    we_seen = mem_we | mem_re;
    tick();
    we_seen = we_seen | mem_we | mem_re;
    checks++; if (err !== 1'b1 || sp_out !== 32'h1C || we_seen !== 1'b0) begin errors++; $display("FAIL both_err: got err=%b sp=%h strobes=%b expected 1 1c 0", err, sp_out, we_seen); end
    tick();
    n_done = 0; we_seen = 1'b0;
    pull_req = 1'b1;
    tick(); pull_req = 1'b0;
    tick();
    push_req = 1'b1; push_data = 32'hDEAD;
    tick();
    push_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) n_done++;
      we_seen = we_seen | mem_we;
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL busy_ignore_done: got %0d pulses expected 1", n_done); end
    checks++; if (we_seen !== 1'b0 || sp_out !== 32'h20 || pull_data !== 32'h10E) begin errors++; $display("FAIL busy_ignore_state: got we=%b sp=%h pd=%h expected 0 20 10e", we_seen, sp_out, pull_data); end
  endtask

  task automatic test_reset_mid();
    pull_req = 1'b1;
    tick(); pull_req = 1'b0;
    tick();
    checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL mid_rd: got %b expected 1", mem_re); end
    Resetn = 1'b0;
    tick();
    checks++; if (sp_out !== 32'h58 || empty !== 1'b1 || pull_data !== 32'h0) begin errors++; $display("FAIL mid_reset: got sp=%h empty=%b pd=%h expected 58 1 0", sp_out, empty, pull_data); end
    checks++; if ({busy, done, sp_we, mem_re} !== 4'b0) begin errors++; $display("FAIL mid_reset_ctl: got %b expected 0000", {busy, done, sp_we, mem_re}); end
    Resetn = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || sp_we !== 1'b0 || sp_out !== 32'h58) begin errors++; $display("FAIL mid_after: got done=%b sp_we=%b sp=%h expected 0 0 58", done, sp_we, sp_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_push();
    test_lifo();
    test_errors();
    test_both_and_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
Sequencing unit for the call/return stack; sits directly downstream of the register file's stack-pointer (r29) and return-address (r31) registers. It owns the architectural SP value and executes one push or pull at a time against a word-addressed data RAM with 1-cycle read latency. It returns the new SP for write-back into r29 and, on a pull, returns the popped word for the PC/r31 path. The stack grows downward.

Parameters:
DATA_W, 32, data and address width
SP_INIT, 32'h00000058, reset SP value and empty-stack address
SP_LIMIT, 32'h00000018, lowest legal SP; full when SP == SP_LIMIT
WORD_BYTES, 4, SP step per push/pull

Ports:
Clock  in  1  single clock; all state changes on negedge Clock, matching register-file timing
Resetn  in  1  synchronous active-low reset
push_req  in  1  request a push; sampled only in IDLE
pull_req  in  1  request a pull; sampled only in IDLE
push_data  in  DATA_W  word to push (return address); latched at acceptance
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when an operation completes
err  out  1  one-cycle pulse when a request is rejected
pull_data  out  DATA_W  popped word; valid from the done pulse until the next pull completes
sp_out  out  DATA_W  current SP
sp_we  out  1  pulse with done; write sp_out into r29
full  out  1  SP == SP_LIMIT
empty  out  1  SP == SP_INIT
mem_addr  out  DATA_W  RAM byte address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe
mem_rdata  in  DATA_W  RAM read data; valid one cycle after mem_re

Behaviour:
- Reset (Resetn = 0 at a negedge, including mid-operation): state IDLE; SP = SP_INIT; pull_data = 0; busy, done, err, sp_we, mem_we and mem_re = 0; mem_addr and mem_wdata = 0. Any in-flight operation is abandoned without a write.
- All outputs are registered. full and empty are decoded from the registered SP.
- States: IDLE, PUSH_WR, PULL_RD, PULL_WAIT, DONE, ERR.
- IDLE, push_req only:
  - If not full: latch push_data and go to PUSH_WR.
  - If full: go to ERR.
- IDLE, pull_req only:
  - If not empty: go to PULL_RD.
  - If empty: go to ERR.
- IDLE, push_req and pull_req together: go to ERR. This case is illegal; SP and memory are untouched.
- PUSH_WR (1 cycle): mem_we = 1, mem_addr = SP - WORD_BYTES, mem_wdata = latched data. SP <= SP - WORD_BYTES. Next state DONE.
- PULL_RD (1 cycle): mem_re = 1, mem_addr = SP. Next state PULL_WAIT.
- PULL_WAIT (1 cycle): pull_data <= mem_rdata; SP <= SP + WORD_BYTES. Next state DONE.
- DONE (1 cycle): done = 1, sp_we = 1. Next state IDLE.
- ERR (1 cycle): err = 1, no memory access, SP unchanged. Next state IDLE.
- Latency, counted in negedges from the acceptance edge:
  - push: done at +2
  - pull: done at +3
  - rejection: err at +1
- Minimum spacing between accepted requests is one IDLE cycle after done or err.
- Requests raised while busy are ignored, not queued.
- SP arithmetic is modulo 2^DATA_W. The full/empty checks guarantee SP stays within [SP_LIMIT, SP_INIT] and never wraps.
- mem_addr bits [1:0] are always 0 when SP_INIT and SP_LIMIT are word-aligned. This is enforced by an elaboration-time check.

Decomposition:
- Shared package stack_pkg holds:
  - the state encoding: IDLE=3'd0, PUSH_WR=3'd1, PULL_RD=3'd2, PULL_WAIT=3'd3, DONE=3'd4, ERR=3'd5
  - SP_INIT and SP_LIMIT defaults and WORD_BYTES
- One natural sub-module, stack_sp_reg: the SP register with reset-to-SP_INIT, inc/dec controls, and full/empty decode.
- The FSM and memory-strobe logic stay in stack_ctrl.

Test Plan:
- Reset, then idle: sp_out = 0x58, empty = 1, full = 0, busy = 0, all strobes = 0.
- Push 0x00400010 from reset: mem_we with addr 0x54, wdata 0x00400010 at +1; done and sp_we at +2 with sp_out = 0x54; busy drops at +3.
- Push 0xA then 0xB, then pull twice:
  - pushes write addresses 0x54 and 0x50
  - the pulls return 0xB then 0xA, each with done at +3
  - sp_out ends at 0x58 and empty = 1
- Pull from empty, and push with SP = SP_LIMIT (after 16 pushes): err pulse at +1; SP, memory and pull_data unchanged; no mem_we or mem_re.
- push_req and pull_req asserted together in IDLE: err at +1, SP unchanged. A push_req asserted during busy is ignored, with no extra done.
- Resetn driven low during PULL_WAIT: at the next negedge, state is IDLE, sp_out = 0x58, no done or sp_we pulse, pull_data = 0.
